dstore_buffer: RTL and testbench
================================

Name: dstore_buffer

Overview:
- Write-side companion to the data cache: accepts store requests from the MEM stage and aligns them into word-wide byte-strobed writes.
- Queues the writes in a small FIFO and drains them one at a time into the data memory over a req/ack handshake.
- Provides byte-granular store-to-load forwarding, so loads to addresses with pending stores return the newest data.

Parameters:
- DEPTH, 4, number of queued store entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- st_valid  input  1  store request from the pipeline.
- st_ready  output  1  buffer can accept a store this cycle.
- st_addr  input  32  byte address of the store.
- st_data  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- st_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- misalign_err  output  1  one-cycle pulse when an accepted store is misaligned or illegal.
- mem_req  output  1  write request to the data memory.
- mem_ack  input  1  data memory has taken the write.
- mem_addr  output  32  word-aligned write address; bits [1:0] are always 00.
- mem_wdata  output  32  lane-aligned write data.
- mem_wstrb  output  4  byte-lane write enables.
- ld_addr  input  32  load probe address (byte address).
- fwd_mask  output  4  byte lanes of word ld_addr[31:2] held in the buffer.
- fwd_data  output  32  forwarded bytes; lanes not set in fwd_mask read 0.
- empty  output  1  no pending entries.

Behaviour:
- Reset (reset = 0, asynchronous), effective immediately, not at the next edge:
  - count, rd_ptr and wr_ptr go to 0; FSM goes to IDLE.
  - mem_req = 0, misalign_err = 0, empty = 1, fwd_mask = 0.
  - Pending stores are discarded, including one mid-handshake.
- Accept:
  - st_ready = (count != DEPTH). No bypass when full, even if a pop happens in the same cycle.
  - A push occurs when st_valid & st_ready is sampled at a rising edge.
- Alignment, with off = st_addr[1:0]:
  - byte: wstrb = 4'b0001 << off; wdata = {4{st_data[7:0]}}.
  - half: legal only when off[0] = 0; wstrb = 4'b0011 << off; wdata = {2{st_data[15:0]}}.
  - word: legal only when off = 00; wstrb = 1111; wdata = st_data.
  - Illegal cases (misaligned half, misaligned word, or size 11): the store is consumed (st_ready handshake completes) but not queued. misalign_err is high for the one cycle after that edge.
- Entry contents: {addr[31:2], wdata, wstrb}. The FIFO wraps modulo DEPTH.
- Drain FSM, states IDLE and REQ:
  - mem_req = (state == REQ). mem_addr, mem_wdata and mem_wstrb come from the head entry and stay stable while mem_req is high.
  - IDLE -> REQ at an edge where count != 0. A store accepted at edge k therefore raises mem_req after edge k+1, a one-cycle bubble.
  - REQ with mem_ack = 1 at an edge: the head is popped.
    - Next state is REQ if count_next != 0, which gives back-to-back drains with no bubble.
    - Otherwise next state is IDLE.
  - REQ with mem_ack = 0: hold the request. There is no timeout.
  - mem_ack while in IDLE is ignored.
- Count update on simultaneous push and pop: count is unchanged and both pointers advance.
- empty = (count == 0).
- Forwarding (combinational, no added latency):
  - For every valid entry with addr[31:2] == ld_addr[31:2], OR its wstrb into fwd_mask.
  - Each forwarded lane takes its byte from the youngest matching entry that writes that lane.
  - The head entry stays visible to forwarding until the edge that pops it.
  - A store pushed in the same cycle is not visible until after its edge.

Test Plan:
- Single word store: st_addr = 0x20, st_data = 0xDEADBEEF, size = 10, mem_ack tied to 1.
  -> mem_req high exactly one cycle, two cycles after the accept edge; mem_addr = 0x20, wstrb = 1111, wdata = 0xDEADBEEF; then empty = 1.
- Byte and half alignment: byte 0xAB at 0x23 -> wstrb = 1000, wdata = 0xABABABAB. Half 0x1234 at 0x26 -> wstrb = 1100, wdata = 0x12341234. Half at 0x25 -> misalign_err pulses, nothing is queued, empty stays 1.
- Full/backpressure: mem_ack = 0, push 5 stores.
  -> st_ready drops after the 4th; the 5th is held by the producer. mem_req with the first entry's address stays high and stable. Raising mem_ack drains all four back-to-back, mem_req is never low between them, and the 5th store is accepted once st_ready returns.
- Forwarding merge: queue word 0x11223344 at 0x40, then byte 0x99 at 0x41; probe ld_addr = 0x40.
  -> fwd_mask = 1111, fwd_data = 0x11229944. Probing ld_addr = 0x44 -> fwd_mask = 0000, fwd_data = 0.
- Simultaneous push and pop at count = 1 while in REQ with mem_ack = 1.
  -> count stays 1, mem_req stays high, and mem_addr switches to the new entry on the next cycle.
- Asynchronous reset mid-handshake: reset driven low between edges while mem_req = 1 and count = 3.
  -> mem_req = 0 and empty = 1 before the next edge; after release, no write is issued and st_ready = 1.

Source files
------------

// File: rtl/dstore_buffer_if.sv
// Store-side, memory-side and forwarding-probe signals of the data store buffer.
// The buffer itself uses the slave modport. The pipeline, memory or bench drives it through the master modport.
interface dstore_buffer_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        misalign_err;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] ld_addr;
  logic [3:0]  fwd_mask;
  logic [31:0] fwd_data;
  logic        empty;

  modport master (
    output st_valid, st_addr, st_data, st_size, mem_ack, ld_addr,
    input  st_ready, misalign_err, mem_req, mem_addr, mem_wdata, mem_wstrb,
           fwd_mask, fwd_data, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_ack, ld_addr,
    output st_ready, misalign_err, mem_req, mem_addr, mem_wdata, mem_wstrb,
           fwd_mask, fwd_data, empty
  );
endinterface

// File: rtl/dstore_buffer.sv
// Store buffer: aligns MEM-stage stores into byte-strobed words, queues them in a FIFO,
// drains them over req/ack, and forwards pending bytes to loads.
module dstore_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic          clock,
  input  logic          reset,
  dstore_buffer_if.slave bus
);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, REQ} state_t;

  typedef struct packed {
    logic        ok;
    logic [3:0]  strb;
    logic [31:0] data;
  } align_t;

  function automatic align_t align_store(input logic [1:0] off, input logic [1:0] size,
                                         input logic [31:0] data);
    align_t a;
    a = '0;
    case (size)
      2'b00: begin
        a.ok   = 1'b1;
        a.strb = 4'b0001 << off;
        a.data = {4{data[7:0]}};
      end
      2'b01: begin
        a.ok   = ~off[0];
        a.strb = 4'b0011 << off;
        a.data = {2{data[15:0]}};
      end
      2'b10: begin
        a.ok   = (off == 2'b00);
        a.strb = 4'b1111;
        a.data = data;
      end
      default: a = '0;
    endcase
    return a;
  endfunction

  logic [29:0]      ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [3:0]       ent_strb [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, fwd_idx;
  logic [CNT_W-1:0] count, count_next;
  state_t           state, state_next;
  align_t           st_al;
  logic             push, enq, pop, mem_req_c, misalign_q;
  logic [3:0]       fwd_mask_c;
  logic [31:0]      fwd_data_c;
  logic             ld_off_unused;

  assign st_al       = align_store(bus.st_addr[1:0], bus.st_size, bus.st_data);
  assign bus.st_ready = (count != CNT_W'(DEPTH));
  assign push        = bus.st_valid & bus.st_ready;
  assign enq         = push & st_al.ok;
  assign pop         = (state == REQ) & bus.mem_ack;
  assign count_next  = count + CNT_W'(enq) - CNT_W'(pop);

  assign bus.empty        = (count == '0);
  assign bus.misalign_err = misalign_q;
  assign bus.mem_req      = mem_req_c;
  assign bus.mem_addr     = {ent_addr[rd_ptr], 2'b00};
  assign bus.mem_wdata    = ent_data[rd_ptr];
  assign bus.mem_wstrb    = ent_strb[rd_ptr];
  assign bus.fwd_mask     = fwd_mask_c;
  assign bus.fwd_data     = fwd_data_c;
  assign ld_off_unused    = ^bus.ld_addr[1:0];

  // Control state: occupancy, pointers and the error pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      misalign_q <= 1'b0;
    end else begin
      count      <= count_next;
      misalign_q <= push & ~st_al.ok;
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Entry payload carries no reset; validity comes from count and rd_ptr
  always_ff @(posedge clock) begin
    if (enq) begin
      ent_addr[wr_ptr] <= bus.st_addr[31:2];
      ent_data[wr_ptr] <= st_al.data;
      ent_strb[wr_ptr] <= st_al.strb;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_req_c  = 1'b0;
    case (state)
      IDLE: if (count != '0) state_next = REQ;
      REQ: begin
        mem_req_c = 1'b1;
        if (bus.mem_ack) state_next = (count_next != '0) ? REQ : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Walk oldest to youngest so a younger matching entry overwrites older lanes
  always_comb begin
    fwd_mask_c = '0;
    fwd_data_c = '0;
    fwd_idx    = rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) && (ent_addr[fwd_idx] == bus.ld_addr[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (ent_strb[fwd_idx][b]) begin
            fwd_mask_c[b]        = 1'b1;
            fwd_data_c[8*b +: 8] = ent_data[fwd_idx][8*b +: 8];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_dstore_buffer.sv
// Self-checking bench for dstore_buffer: directed scenarios plus a randomized run
// scored against a queue-based reference model.
module tb_dstore_buffer;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dstore_buffer_if bus();
  dstore_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t mq[$];
  wr_t obsq[$];
  wr_t expq[$];
  int  tests_run = 0;
  int  tests_failed = 0;
  bit  last_acc, last_hs, exp_mis;

  function automatic void ref_align(input logic [31:0] a, input logic [31:0] d,
                                    input logic [1:0] sz, output bit ok,
                                    output logic [3:0] strb, output logic [31:0] wd);
    int lane;
    lane = int'(a[1:0]);
    ok = 0; strb = 4'h0; wd = 32'h0;
    if (sz == 2'd0) begin
      ok = 1; strb = 4'(1 << lane); wd = d[7:0] * 32'h0101_0101;
    end else if (sz == 2'd1) begin
      ok = (lane % 2 == 0); strb = 4'(3 << lane); wd = d[15:0] * 32'h0001_0001;
    end else if (sz == 2'd2) begin
      ok = (lane == 0); strb = 4'hF; wd = d;
    end
  endfunction

  // Youngest-first search per lane over the model queue
  function automatic void ref_fwd(input logic [31:0] la, output logic [3:0] m, output logic [31:0] d);
    m = 4'h0; d = 32'h0;
    for (int lane = 0; lane < 4; lane++) begin
      for (int j = mq.size() - 1; j >= 0; j--) begin
        if (mq[j].addr[31:2] == la[31:2] && mq[j].strb[lane]) begin
          m[lane] = 1'b1;
          d[lane*8 +: 8] = mq[j].data[lane*8 +: 8];
          break;
        end
      end
    end
  endfunction

  task automatic drive_st(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    bus.st_valid = v; bus.st_addr = a; bus.st_data = d; bus.st_size = sz;
  endtask

  // Samples the pre-edge handshakes, advances the model, then crosses one rising edge
  task automatic tick();
    bit ok; logic [3:0] s; logic [31:0] d;
    #1;
    last_acc = bus.st_valid && bus.st_ready;
    last_hs  = bus.mem_req && bus.mem_ack;
    if (last_hs) begin
      obsq.push_back('{bus.mem_addr, bus.mem_wdata, bus.mem_wstrb});
      if (mq.size() != 0) expq.push_back(mq.pop_front());
      else expq.push_back('{32'hFFFF_FFFF, 32'h0, 4'h0});
    end
    exp_mis = 0;
    if (last_acc) begin
      ref_align(bus.st_addr, bus.st_data, bus.st_size, ok, s, d);
      if (ok) mq.push_back('{{bus.st_addr[31:2], 2'b00}, d, s});
      exp_mis = !ok;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain(output bit ok);
    drive_st(0, 32'h0, 32'h0, 2'b00);
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 20 && !bus.empty; i++) tick();
    ok = bus.empty;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    tests_run++;
    if ({bus.mem_req, bus.misalign_err, bus.empty, bus.fwd_mask, bus.st_ready} !== 8'b0_0_1_0000_1) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b required %b",
               {bus.mem_req, bus.misalign_err, bus.empty, bus.fwd_mask, bus.st_ready}, 8'b0_0_1_0000_1);
    end
    tests_run++;
    if (bus.fwd_data !== 32'h0) begin
      tests_failed++; $display("FAIL reset_fwd_data: got %h required 0", bus.fwd_data);
    end
    #9 reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_single_word();
    bit ok;
    bus.mem_ack = 1'b1;
    drive_st(1, 32'h20, 32'hDEAD_BEEF, 2'b10);
    tick();
    drive_st(0, 32'h0, 32'h0, 2'b00);
    tests_run++;
    if ({last_acc, bus.mem_req, bus.empty} !== 3'b100) begin
      tests_failed++; $display("FAIL sw_bubble: got acc/req/empty %b required 100", {last_acc, bus.mem_req, bus.empty});
    end
    tick();
    tests_run++;
    if ({bus.mem_req, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata} !== {1'b1, 32'h20, 4'hF, 32'hDEAD_BEEF}) begin
      tests_failed++;
      $display("FAIL sw_req: got req=%b addr=%h strb=%b data=%h required 1/00000020/1111/deadbeef",
               bus.mem_req, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata);
    end
    tick();
    tests_run++;
    if ({bus.mem_req, bus.empty, last_hs} !== 3'b011) begin
      tests_failed++; $display("FAIL sw_done: got req/empty/hs %b required 011", {bus.mem_req, bus.empty, last_hs});
    end
    drain(ok);
  endtask

  task automatic test_alignment();
    bit ok;
    bus.mem_ack = 1'b0;
    drive_st(1, 32'h23, 32'h0000_00AB, 2'b00); tick();
    drive_st(1, 32'h26, 32'h0000_1234, 2'b01); tick();
    drive_st(0, 32'h0, 32'h0, 2'b00);
    tests_run++;
    if ({bus.mem_req, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata} !== {1'b1, 32'h20, 4'b1000, 32'hABAB_ABAB}) begin
      tests_failed++;
      $display("FAIL align_byte: got req=%b addr=%h strb=%b data=%h required 1/00000020/1000/abababab",
               bus.mem_req, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata);
    end
    bus.mem_ack = 1'b1;
    tick();
    tests_run++;
    if ({bus.mem_req, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata} !== {1'b1, 32'h24, 4'b1100, 32'h1234_1234}) begin
      tests_failed++;
      $display("FAIL align_half: got req=%b addr=%h strb=%b data=%h required 1/00000024/1100/12341234",
               bus.mem_req, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata);
    end
    drain(ok);
    drive_st(1, 32'h25, 32'h0000_5678, 2'b01);
    tick();
    drive_st(0, 32'h0, 32'h0, 2'b00);
    tests_run++;
    if ({last_acc, bus.misalign_err, bus.empty} !== 3'b111) begin
      tests_failed++; $display("FAIL align_mis_pulse: got acc/err/empty %b required 111", {last_acc, bus.misalign_err, bus.empty});
    end
    tick();
    tests_run++;
    if ({bus.misalign_err, bus.empty, bus.mem_req} !== 3'b010) begin
      tests_failed++; $display("FAIL align_mis_after: got err/empty/req %b required 010", {bus.misalign_err, bus.empty, bus.mem_req});
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] bd[5];
    int acc = 0;
    int guard = 0;
    bit stable = 1, gap = 0, got5 = 0, ok;
    obsq.delete(); expq.delete();
    for (int i = 0; i < 5; i++) bd[i] = $urandom;
    bus.mem_ack = 1'b0;
    for (int cyc = 0; cyc < 8 && acc < 4; cyc++) begin
      drive_st(1, 32'h100 + 32'(4 * acc), bd[acc], 2'b10);
      tick();
      if (last_acc) acc++;
    end
    drive_st(1, 32'h110, bd[4], 2'b10);
    #1;
    tests_run++;
    if (acc != 4 || bus.st_ready !== 1'b0) begin
      tests_failed++; $display("FAIL bp_full: got accepted=%0d ready=%b required 4/0", acc, bus.st_ready);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (last_acc || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_wdata !== bd[0]) stable = 0;
    end
    tests_run++;
    if (!stable) begin
      tests_failed++; $display("FAIL bp_hold: got req=%b addr=%h required stable 1/00000100", bus.mem_req, bus.mem_addr);
    end
    bus.mem_ack = 1'b1;
    tick();
    tests_run++;
    if ({last_hs, last_acc} !== 2'b10) begin
      tests_failed++; $display("FAIL bp_no_bypass: got hs/acc %b required 10", {last_hs, last_acc});
    end
    while (!bus.empty && guard < 12) begin
      if (!bus.mem_req) gap = 1;
      tick();
      if (last_acc) begin got5 = 1; drive_st(0, 32'h0, 32'h0, 2'b00); end
      guard++;
    end
    tests_run++;
    if ({got5, gap, bus.empty} !== 3'b101) begin
      tests_failed++; $display("FAIL bp_drain: got accepted5/gap/empty %b required 101", {got5, gap, bus.empty});
    end
    tests_run++;
    if (obsq.size() != 5) begin
      tests_failed++; $display("FAIL bp_count: got %0d writes required 5", obsq.size());
    end
    for (int i = 0; i < obsq.size() && i < 5; i++) begin
      tests_run++;
      if (obsq[i].addr !== 32'h100 + 32'(4 * i) || obsq[i].data !== bd[i] || obsq[i].strb !== 4'hF) begin
        tests_failed++;
        $display("FAIL bp_write%0d: got %h/%h/%b required %h/%h/1111", i, obsq[i].addr, obsq[i].data,
                 obsq[i].strb, 32'h100 + 32'(4 * i), bd[i]);
      end
    end
    drain(ok);
  endtask

  task automatic test_forward();
    logic [3:0] m; logic [31:0] d; bit ok;
    bus.mem_ack = 1'b0;
    drive_st(1, 32'h40, 32'h1122_3344, 2'b10); tick();
    drive_st(1, 32'h41, 32'h0000_0099, 2'b00); tick();
    drive_st(0, 32'h0, 32'h0, 2'b00);
    bus.ld_addr = 32'h40;
    #1;
    ref_fwd(bus.ld_addr, m, d);
    tests_run++;
    if ({bus.fwd_mask, bus.fwd_data} !== {4'hF, 32'h1122_9944} || {m, d} !== {4'hF, 32'h1122_9944}) begin
      tests_failed++;
      $display("FAIL fwd_merge: got %b/%h model %b/%h required 1111/11229944", bus.fwd_mask, bus.fwd_data, m, d);
    end
    bus.ld_addr = 32'h44;
    #1;
    tests_run++;
    if ({bus.fwd_mask, bus.fwd_data} !== 36'h0) begin
      tests_failed++; $display("FAIL fwd_miss: got %b/%h required 0000/00000000", bus.fwd_mask, bus.fwd_data);
    end
    drive_st(1, 32'h46, 32'h0000_0077, 2'b00);
    #1;
    tests_run++;
    if (bus.fwd_mask !== 4'h0) begin
      tests_failed++; $display("FAIL fwd_same_cycle: got %b required 0000", bus.fwd_mask);
    end
    tick();
    drive_st(0, 32'h0, 32'h0, 2'b00);
    tests_run++;
    if ({bus.fwd_mask, bus.fwd_data} !== {4'b0100, 32'h0077_0000}) begin
      tests_failed++; $display("FAIL fwd_after_edge: got %b/%h required 0100/00770000", bus.fwd_mask, bus.fwd_data);
    end
    drain(ok);
    tests_run++;
    if (!ok || bus.fwd_mask !== 4'h0) begin
      tests_failed++; $display("FAIL fwd_drain: got empty=%b mask=%b required 1/0000", bus.empty, bus.fwd_mask);
    end
  endtask

  task automatic test_push_pop();
    bit ok;
    bus.mem_ack = 1'b1;
    drive_st(1, 32'h200, 32'hAAAA_0001, 2'b10); tick();
    drive_st(0, 32'h0, 32'h0, 2'b00); tick();
    drive_st(1, 32'h204, 32'hBBBB_0002, 2'b10);
    tick();
    drive_st(0, 32'h0, 32'h0, 2'b00);
    tests_run++;
    if ({last_hs, last_acc, bus.mem_req, bus.empty, bus.mem_addr} !== {4'b1110, 32'h204}) begin
      tests_failed++;
      $display("FAIL pp_swap: got hs/acc/req/empty %b addr %h required 1110/00000204",
               {last_hs, last_acc, bus.mem_req, bus.empty}, bus.mem_addr);
    end
    tick();
    tests_run++;
    if ({last_hs, bus.mem_req, bus.empty} !== 3'b101) begin
      tests_failed++; $display("FAIL pp_count_one: got hs/req/empty %b required 101", {last_hs, bus.mem_req, bus.empty});
    end
    drain(ok);
  endtask

  task automatic test_async_reset();
    bit bad = 0;
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_st(1, 32'h300 + 32'(4 * i), $urandom, 2'b10);
      tick();
    end
    drive_st(0, 32'h0, 32'h0, 2'b00);
    bus.ld_addr = 32'h300;
    tick();
    tests_run++;
    if ({bus.mem_req, bus.empty, bus.fwd_mask} !== 6'b10_1111) begin
      tests_failed++; $display("FAIL ar_setup: got req/empty/mask %b required 101111", {bus.mem_req, bus.empty, bus.fwd_mask});
    end
    #3 reset = 1'b0;
    #1;
    mq.delete();
    tests_run++;
    if ({bus.mem_req, bus.empty, bus.fwd_mask, bus.st_ready} !== 7'b01_0000_1) begin
      tests_failed++;
      $display("FAIL ar_immediate: got req/empty/mask/ready %b required 0100001",
               {bus.mem_req, bus.empty, bus.fwd_mask, bus.st_ready});
    end
    @(posedge clock);
    #3 reset = 1'b1;
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.mem_req || last_hs || !bus.st_ready || !bus.empty) bad = 1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++; $display("FAIL ar_after: got req=%b ready=%b empty=%b required 0/1/1", bus.mem_req, bus.st_ready, bus.empty);
    end
  endtask

  task automatic test_random();
    logic [3:0] m; logic [31:0] d; bit ok; int r;
    obsq.delete(); expq.delete(); mq.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      r = $urandom_range(0, 9);
      drive_st(1'($urandom_range(0, 1)), 32'h80 + 32'($urandom_range(0, 15)), $urandom,
               (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11);
      bus.mem_ack = 1'($urandom_range(0, 1));
      bus.ld_addr = 32'h80 + 32'($urandom_range(0, 15));
      #1;
      ref_fwd(bus.ld_addr, m, d);
      tests_run++;
      if ({bus.fwd_mask, bus.fwd_data} !== {m, d}) begin
        tests_failed++; $display("FAIL rnd_fwd@%0d: got %b/%h required %b/%h", cyc, bus.fwd_mask, bus.fwd_data, m, d);
      end
      tests_run++;
      if ({bus.empty, bus.st_ready, bus.misalign_err} !== {mq.size() == 0, mq.size() != DEPTH, exp_mis}) begin
        tests_failed++;
        $display("FAIL rnd_status@%0d: got empty/ready/err %b required %b", cyc,
                 {bus.empty, bus.st_ready, bus.misalign_err}, {mq.size() == 0, mq.size() != DEPTH, exp_mis});
      end
      if (bus.mem_req) begin
        tests_run++;
        if (mq.size() == 0) begin
          tests_failed++; $display("FAIL rnd_head@%0d: got request with model empty required no request", cyc);
        end else if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== {mq[0].addr, mq[0].data, mq[0].strb}) begin
          tests_failed++;
          $display("FAIL rnd_head@%0d: got %h/%h/%b required %h/%h/%b", cyc, bus.mem_addr, bus.mem_wdata,
                   bus.mem_wstrb, mq[0].addr, mq[0].data, mq[0].strb);
        end
      end
      tick();
    end
    drain(ok);
    tests_run++;
    if (!ok || obsq.size() != expq.size() || mq.size() != 0) begin
      tests_failed++;
      $display("FAIL rnd_drain: got empty=%b writes=%0d model=%0d left=%0d required 1/equal/0", ok,
               obsq.size(), expq.size(), mq.size());
    end
    for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
      tests_run++;
      if ({obsq[i].addr, obsq[i].data, obsq[i].strb} !== {expq[i].addr, expq[i].data, expq[i].strb}) begin
        tests_failed++;
        $display("FAIL rnd_write%0d: got %h/%h/%b required %h/%h/%b", i, obsq[i].addr, obsq[i].data,
                 obsq[i].strb, expq[i].addr, expq[i].data, expq[i].strb);
      end
    end
  endtask

  initial begin
    drive_st(0, 32'h0, 32'h0, 2'b00);
    bus.mem_ack = 1'b0;
    bus.ld_addr = 32'h0;
    exp_mis = 0;
    test_reset();
    test_single_word();
    test_alignment();
    test_backpressure();
    test_forward();
    test_push_pop();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
